// File: rtl/x1_io_pkg.sv
// Shared definitions for the X1 I/O-bus interval timer: register map, control/status
// bit positions, prescale encodings and the prescaler tick mask.
package x1_io_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_CNT_L  = 2'd1;
    localparam logic [1:0] OFF_CNT_H  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_PS_LO = 4;

    localparam int STAT_PEND = 0;
    localparam int STAT_EN   = 1;

    localparam logic [1:0] PS_DIV1    = 2'd0;
    localparam logic [1:0] PS_DIV16   = 2'd1;
    localparam logic [1:0] PS_DIV256  = 2'd2;
    localparam logic [1:0] PS_DIV4096 = 2'd3;

    typedef struct packed {
        logic [1:0] ps;
        logic       ie;
        logic       auto_rl;
        logic       en;
    } ctrl_t;

    // A tick is due when every prescaler bit selected by this mask is one.
    function automatic logic [11:0] ps_mask(input logic [1:0] ps);
        case (ps)
            PS_DIV1:   ps_mask = 12'h000;
            PS_DIV16:  ps_mask = 12'h00F;
            PS_DIV256: ps_mask = 12'h0FF;
            default:   ps_mask = 12'hFFF;
        endcase
    endfunction

endpackage

// File: rtl/z80_bus_strobe.sv
// One-shot strobe: pulses on the first cep edge of a bus cycle where the select
// level is high, and stays quiet for the rest of that cycle.
module z80_bus_strobe (
    input  logic clock,
    input  logic reset_n,
    input  logic cep,
    input  logic sel,
    output logic pulse
);

    logic sel_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= 1'b0;
        end else if (cep) begin
            sel_q <= sel;
        end
    end

    assign pulse = cep && sel && !sel_q;

endmodule

// File: rtl/x1_io_timer.sv
// Z80 I/O-bus programmable 16-bit interval timer with prescaler, auto-reload and
// an active-low interrupt raised on terminal count.
module x1_io_timer
    import x1_io_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h1FA0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cep,
    input  logic        iorq,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic [7:0]  di,
    output logic [7:0]  data_out,
    output logic        oe,
    output logic        int_n
);

    logic        sel, rsel, wsel;
    logic        wr_pulse, rd_pulse;
    logic        wr_ctrl, wr_lo, wr_hi, wr_stat;
    logic        tick, load, terminal;
    ctrl_t       ctrl;
    logic [15:0] reload;
    logic [15:0] count;
    logic [7:0]  shadow;
    logic        pend;
    logic [11:0] pre;

    assign sel  = !iorq && (a[15:2] == BASE[15:2]);
    assign rsel = sel && wr;
    assign wsel = sel && !wr;

    z80_bus_strobe u_wr_strobe (
        .clock   (clock),
        .reset_n (reset_n),
        .cep     (cep),
        .sel     (wsel),
        .pulse   (wr_pulse)
    );

    z80_bus_strobe u_rd_strobe (
        .clock   (clock),
        .reset_n (reset_n),
        .cep     (cep),
        .sel     (rsel),
        .pulse   (rd_pulse)
    );

    assign wr_ctrl = wr_pulse && (a[1:0] == OFF_CTRL);
    assign wr_lo   = wr_pulse && (a[1:0] == OFF_CNT_L);
    assign wr_hi   = wr_pulse && (a[1:0] == OFF_CNT_H);
    assign wr_stat = wr_pulse && (a[1:0] == OFF_STATUS);

    assign tick     = cep && ctrl.en && ((pre & ps_mask(ctrl.ps)) == ps_mask(ctrl.ps));
    assign load     = wr_ctrl && di[CTRL_EN];
    // A CTRL write on the same edge as a tick swallows the tick entirely.
    assign terminal = tick && !wr_ctrl && (count == 16'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl   <= '0;
            reload <= 16'd0;
            count  <= 16'd0;
            shadow <= 8'd0;
            pend   <= 1'b0;
            pre    <= 12'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= '{ps:      di[CTRL_PS_LO +: 2],
                          ie:      di[CTRL_IE],
                          auto_rl: di[CTRL_AUTO],
                          en:      di[CTRL_EN]};
            end else if (terminal && !ctrl.auto_rl) begin
                ctrl.en <= 1'b0;
            end

            if (load) begin
                pre <= 12'd0;
            end else if (cep && ctrl.en) begin
                pre <= pre + 12'd1;
            end

            if (load) begin
                count <= reload;
            end else if (tick && !wr_ctrl) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (ctrl.auto_rl) begin
                    count <= reload;
                end
            end

            if (wr_lo) reload[7:0]  <= di;
            if (wr_hi) reload[15:8] <= di;

            // A fresh terminal event beats a simultaneous clear.
            if (terminal) begin
                pend <= 1'b1;
            end else if (wr_stat && di[STAT_PEND]) begin
                pend <= 1'b0;
            end

            if (rd_pulse && (a[1:0] == OFF_CNT_L)) begin
                shadow <= count[15:8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int_n <= 1'b1;
        end else begin
            int_n <= !(pend && ctrl.ie);
        end
    end

    assign oe = rsel && reset_n;

    always_comb begin
        data_out = 8'hFF;
        if (oe) begin
            case (a[1:0])
                OFF_CTRL:   data_out = {2'b00, ctrl.ps, 1'b0, ctrl.ie, ctrl.auto_rl, ctrl.en};
                OFF_CNT_L:  data_out = count[7:0];
                OFF_CNT_H:  data_out = shadow;
                default:    data_out = {6'b0, ctrl.en, pend};
            endcase
        end
    end

endmodule

// File: tb/tb_x1_io_timer.sv
// Bench for x1_io_timer: directed bus scenarios followed by randomized bus traffic,
// all compared against a transaction-level model of the timer kept here.
module tb_x1_io_timer;

    localparam logic [15:0] BASE = 16'h1FA0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cep;
    logic        iorq;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  di;
    logic [7:0]  data_out;
    logic        oe;
    logic        int_n;

    x1_io_timer #(.BASE(BASE)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cep      (cep),
        .iorq     (iorq),
        .wr       (wr),
        .a        (a),
        .di       (di),
        .data_out (data_out),
        .oe       (oe),
        .int_n    (int_n)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_en, m_auto, m_ie, m_pend, m_int_n;
    bit [1:0] m_ps;
    int       m_reload, m_count, m_pre;
    bit [7:0] m_shadow;
    bit       w_fired, r_fired;   // has this bus cycle already performed its action
    bit       cep_rand;
    logic     last_oe;

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_int_n = 1; m_ps = 0;
        m_reload = 0; m_count = 0; m_pre = 0; m_shadow = 0;
        w_fired = 0; r_fired = 0;
    endtask

    function automatic bit bus_match();
        return !iorq && (a[15:2] == BASE[15:2]);
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] off);
        case (off)
            2'd0:    return {2'b00, m_ps, 1'b0, m_ie, m_auto, m_en};
            2'd1:    return 8'(m_count);
            2'd2:    return m_shadow;
            default: return {6'b0, m_en, m_pend};
        endcase
    endfunction

    function automatic logic exp_oe();
        return reset_n && bus_match() && wr;
    endfunction

    function automatic logic [7:0] exp_dout();
        return exp_oe() ? exp_read(a[1:0]) : 8'hFF;
    endfunction

    task automatic model_clock(input bit c);
        bit nxt_int, s, wf, rf, ctrl_w, tick, term;
        int div, old_reload;
        bit [1:0] off;
        nxt_int = !(m_pend && m_ie);
        if (c) begin
            s   = bus_match();
            off = a[1:0];
            wf  = s && !wr && !w_fired;
            rf  = s && wr && !r_fired;
            if (s && !wr) w_fired = 1;
            if (s && wr)  r_fired = 1;
            old_reload = m_reload;
            div    = 1 << (4 * m_ps);
            tick   = m_en && ((m_pre % div) == div - 1);
            ctrl_w = wf && (off == 2'd0);
            term   = tick && !ctrl_w && (m_count == 0);
            if (rf && off == 2'd1) m_shadow = 8'(m_count >> 8);
            if (m_en) m_pre = (m_pre + 1) % 4096;
            if (tick && !ctrl_w) begin
                if (m_count > 0) m_count = m_count - 1;
                else if (m_auto) m_count = old_reload;
                else m_en = 0;
            end
            if (wf && off == 2'd3 && di[0]) m_pend = 0;
            if (term) m_pend = 1;
            if (wf && off == 2'd1) m_reload = (m_reload & 16'hFF00) | int'(di);
            if (wf && off == 2'd2) m_reload = (m_reload & 16'h00FF) | (int'(di) << 8);
            if (ctrl_w) begin
                m_en = di[0]; m_auto = di[1]; m_ie = di[2]; m_ps = di[5:4];
                if (di[0]) begin
                    m_count = old_reload;
                    m_pre   = 0;
                end
            end
        end
        m_int_n = nxt_int;
    endtask

    // ---------------- driver tasks ----------------
    function automatic bit pick_cep();
        return cep_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    endfunction

    // One clock: DUT and model advance at posedge, outputs checked at negedge.
    task automatic step(input bit c);
        cep = c;
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_clock(c);
        @(negedge clock);
        check("int_n", 16'(int_n), 16'(m_int_n));
        check("oe", 16'(oe), 16'(exp_oe()));
        check("data_out", 16'(data_out), 16'(exp_dout()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(pick_cep());
    endtask

    task automatic bus(input bit is_wr, input logic [15:0] addr, input logic [7:0] data,
                       input int len, output logic [7:0] rdata);
        iorq = 1'b0; wr = !is_wr; a = addr; di = data;
        w_fired = 0; r_fired = 0;
        #1;
        rdata   = data_out;
        last_oe = oe;
        for (int i = 0; i < len; i++) step(pick_cep());
        iorq = 1'b1; wr = 1'b1; a = 16'($urandom); di = 8'($urandom);
        step(1'b1);
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [7:0] data);
        logic [7:0] unused;
        bus(1'b1, BASE | 16'(off), data, 1, unused);
    endtask

    task automatic rd_reg(input logic [1:0] off, output logic [7:0] rdata);
        bus(1'b0, BASE | 16'(off), 8'h00, 1, rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  rv;
        logic [15:0] na;
        logic [1:0]  off;
        int          op;

        reset_n = 1'b0; cep = 1'b1; iorq = 1'b0; wr = 1'b1; a = BASE; di = 8'h00;
        cep_rand = 0;
        model_reset();

        // Reset held while a CTRL read is on the bus
        repeat (3) step(1'b1);
        check("rst_int_n", 16'(int_n), 16'h1);
        check("rst_oe", 16'(oe), 16'h0);
        check("rst_dout", 16'(data_out), 16'hFF);
        reset_n = 1'b1;
        #1;
        check("rst_rd_ctrl", 16'(data_out), 16'h00);
        check("rst_rd_oe", 16'(oe), 16'h1);
        step(1'b1);
        iorq = 1'b1;
        step(1'b1);

        // Periodic auto-reload, RELOAD=3
        wr_reg(2'd1, 8'h03);
        wr_reg(2'd2, 8'h00);
        wr_reg(2'd0, 8'h07);
        repeat (3) step(1'b1);
        check("irq_pre", 16'(int_n), 16'h1);
        step(1'b1);
        check("irq_fall_5cep", 16'(int_n), 16'h0);
        wr_reg(2'd3, 8'h01);
        check("irq_clear", 16'(int_n), 16'h1);
        step(1'b1);
        check("irq_gap", 16'(int_n), 16'h1);
        step(1'b1);
        check("irq_period4", 16'(int_n), 16'h0);

        // One-shot, RELOAD=2
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd3, 8'h01);
        wr_reg(2'd1, 8'h02);
        wr_reg(2'd0, 8'h05);
        repeat (2) step(1'b1);
        rd_reg(2'd3, rv);
        check("oneshot_status", 16'(rv), 16'h01);
        idle(30);
        wr_reg(2'd3, 8'h01);
        idle(10);
        rd_reg(2'd3, rv);
        check("oneshot_no_retrig", 16'(rv), 16'h00);

        // Long write cycle must load only once
        bus(1'b1, BASE, 8'h01, 6, rv);
        rd_reg(2'd1, rv);
        check("longwr_count", 16'(rv), 16'h00);
        rd_reg(2'd3, rv);
        check("longwr_status", 16'(rv), 16'h01);

        // Snapshot of COUNT high byte
        wr_reg(2'd3, 8'h01);
        wr_reg(2'd1, 8'h34);
        wr_reg(2'd2, 8'h12);
        wr_reg(2'd0, 8'h31);
        rd_reg(2'd1, rv);
        check("snap_lo", 16'(rv), 16'h34);
        rd_reg(2'd2, rv);
        check("snap_hi", 16'(rv), 16'h12);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd0, 8'h01);
        rd_reg(2'd1, rv);
        check("snap2_lo", 16'(rv), 16'hFF);
        idle(600);
        rd_reg(2'd2, rv);
        check("snap2_hold", 16'(rv), 16'h11);

        // Terminal count colliding with a STATUS clear
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd3, 8'h01);
        wr_reg(2'd1, 8'h03);
        wr_reg(2'd2, 8'h00);
        wr_reg(2'd0, 8'h07);
        repeat (2) step(1'b1);
        wr_reg(2'd3, 8'h01);
        check("collide_int_n", 16'(int_n), 16'h0);
        rd_reg(2'd3, rv);
        check("collide_status", 16'(rv), 16'h03);

        // Neighbouring address is ignored
        bus(1'b1, BASE + 16'd4, 8'hFF, 2, rv);
        bus(1'b1, BASE + 16'd7, 8'h01, 2, rv);
        bus(1'b0, BASE + 16'd4, 8'h00, 1, rv);
        check("nomatch_dout", 16'(rv), 16'hFF);
        check("nomatch_oe", 16'(last_oe), 16'h0);
        rd_reg(2'd3, rv);
        check("nomatch_status", 16'(rv), 16'h03);
        rd_reg(2'd0, rv);
        check("nomatch_ctrl", 16'(rv), 16'h07);

        // Randomized traffic with a gated cep
        cep_rand = 1;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: bus(1'b1, BASE, {2'b00, 2'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 7))},
                          $urandom_range(1, 4), rv);
                2: bus(1'b1, BASE | 16'd1, 8'($urandom_range(0, 15)), $urandom_range(1, 4), rv);
                3: bus(1'b1, BASE | 16'd2, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'h00,
                       $urandom_range(1, 4), rv);
                4: bus(1'b1, BASE | 16'd3, 8'($urandom), $urandom_range(1, 4), rv);
                5, 6: bus(1'b0, BASE | 16'($urandom_range(0, 3)), 8'h00, $urandom_range(1, 4), rv);
                7: idle($urandom_range(1, 20));
                8: begin
                    case ($urandom_range(0, 3))
                        0: na = BASE + 16'd4;
                        1: na = BASE - 16'd4;
                        2: na = BASE ^ 16'h8000;
                        default: na = BASE + 16'h0100;
                    endcase
                    bus($urandom_range(0, 1) == 1, na | 16'($urandom_range(0, 3)), 8'($urandom),
                        $urandom_range(1, 4), rv);
                end
                default: begin
                    // Reset pulse in the middle of a bus cycle
                    off  = 2'($urandom_range(0, 3));
                    iorq = 1'b0; wr = 1'($urandom); a = BASE | 16'(off); di = 8'($urandom) & 8'h1F;
                    w_fired = 0; r_fired = 0;
                    step(pick_cep());
                    reset_n = 1'b0;
                    model_reset();
                    step(pick_cep());
                    reset_n = 1'b1;
                    step(1'b1);
                    step(pick_cep());
                    iorq = 1'b1; wr = 1'b1;
                    step(1'b1);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
